// File: rtl/picosoc_dmem_arbiter_if.sv
// picosoc_dmem_arbiter_if: CPU, accelerator and dmem signal bundle.
// slave = arbiter side; master = requesters plus dmem side.
interface picosoc_dmem_arbiter_if #(
  parameter int ADDR_W = 18
);
  logic              cpu_valid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_wstrb;
  logic              cpu_ready;
  logic [31:0]       cpu_rdata;

  logic              acc_valid;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_wstrb;
  logic              acc_ready;
  logic [31:0]       acc_rdata;

  logic              mem_renb;
  logic [ADDR_W-1:0] mem_raddr;
  logic              mem_wenb;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_ready, cpu_rdata,
    input  acc_valid, acc_addr, acc_wdata, acc_wstrb,
    output acc_ready, acc_rdata,
    output mem_renb, mem_raddr,
    output mem_wenb, mem_wstrb, mem_waddr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_ready, cpu_rdata,
    output acc_valid, acc_addr, acc_wdata, acc_wstrb,
    input  acc_ready, acc_rdata,
    input  mem_renb, mem_raddr,
    input  mem_wenb, mem_wstrb, mem_waddr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/picosoc_dmem_arbiter.sv
// picosoc_dmem_arbiter: serialises CPU/accel dmem accesses, anti-starvation.
// Ports: clk, resetn, bus (cpu_*, acc_*, mem_*), arb_busy, arb_owner.
module picosoc_dmem_arbiter #(
  parameter int MEM_DELAY    = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 18
) (
  input  logic                 clk,
  input  logic                 resetn,
  picosoc_dmem_arbiter_if.slave bus,
  output logic                 arb_busy,
  output logic                 arb_owner
);

  localparam int CNT_W = $clog2(MEM_DELAY + 1);
  localparam logic [CNT_W-1:0] DLY = CNT_W'(MEM_DELAY);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        starve_cnt, starve_d;
  logic              owner_q, owner_d;
  logic              cpu_rdy_q, acc_rdy_q;
  logic              rdy_d;

  logic              starved;
  logic              grant_acc;
  logic              issue;
  logic              is_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_wstrb;

  always_comb begin
    starved = bus.acc_valid
           && (STARVE_LIMIT != 0)
           && (starve_cnt >= LIM);
    grant_acc = !(bus.cpu_valid && !starved);
    // resetn gates issue so enables stay low in reset
    issue = resetn
         && (state_q == IDLE)
         && (bus.cpu_valid || bus.acc_valid);
  end

  always_comb begin
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    sel_wstrb = bus.cpu_wstrb;
    unique case (1'b1)
      grant_acc: begin
        sel_addr  = bus.acc_addr;
        sel_wdata = bus.acc_wdata;
        sel_wstrb = bus.acc_wstrb;
      end
      !grant_acc: begin
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        sel_wstrb = bus.cpu_wstrb;
      end
    endcase
    is_wr = |sel_wstrb;
  end

  always_comb begin
    bus.mem_renb  = 1'b0;
    bus.mem_raddr = '0;
    bus.mem_wenb  = 1'b0;
    bus.mem_waddr = '0;
    bus.mem_wstrb = '0;
    bus.mem_wdata = '0;
    if (issue) begin
      if (is_wr) begin
        bus.mem_wenb  = 1'b1;
        bus.mem_waddr = sel_addr;
        bus.mem_wstrb = sel_wstrb;
        bus.mem_wdata = sel_wdata;
      end else begin
        bus.mem_renb  = 1'b1;
        bus.mem_raddr = sel_addr;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    starve_d = starve_cnt;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = WAIT;
          cnt_d   = DLY;
          owner_d = grant_acc;
          if (grant_acc) begin
            starve_d = '0;
          end else if (bus.acc_valid
                    && starve_cnt != 8'hFF) begin
            starve_d = starve_cnt + 8'd1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) begin
          state_d = IDLE;
        end
      end
    endcase
    // ready lands in the cycle where the counter reads 1
    rdy_d = (cnt_d == ONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      starve_cnt <= '0;
      owner_q    <= 1'b0;
      cpu_rdy_q  <= 1'b0;
      acc_rdy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_cnt <= starve_d;
      owner_q    <= owner_d;
      cpu_rdy_q  <= rdy_d && !owner_d;
      acc_rdy_q  <= rdy_d && owner_d;
    end
  end

  assign bus.cpu_ready = cpu_rdy_q;
  assign bus.acc_ready = acc_rdy_q;
  assign bus.cpu_rdata = resetn ? bus.mem_rdata : '0;
  assign bus.acc_rdata = resetn ? bus.mem_rdata : '0;
  assign arb_busy      = (state_q == WAIT);
  assign arb_owner     = owner_q;

endmodule

// File: doc/picosoc_dmem_arbiter.md
# picosoc_dmem_arbiter

Two-port arbiter that shares the single-port-per-direction `picosoc_dmem` between the CPU data bus and the accelerator (`al_accel`) memory master. It replaces the fixed-priority `is_cpu_get_ram` mux and the free-running `cpu_ram_ready` / `al_accel_ram_*_ready` shift registers. It serialises accesses, generates per-port ready pulses aligned to memory latency, and guarantees accelerator forward progress with a starvation limit. It sits between the CPU/accelerator address decode and the `dmem` instance inside `al_picosoc`.

## Interface
- `MEM_DELAY`, 1, dmem read latency in cycles, ≥1.
- `STARVE_LIMIT`, 4, consecutive lost arbitrations after which accel wins; 0 = strict CPU priority; max 255.
- `ADDR_W`, 18, word address width, matching `mem_addr[19:2]`.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `cpu_valid` in 1: CPU request, already decoded to dmem range; held until `cpu_ready`.
- `cpu_addr` in ADDR_W: CPU word address.
- `cpu_wdata` in 32: CPU write data.
- `cpu_wstrb` in 4: byte strobes; 0 = read.
- `cpu_ready` out 1: one-cycle completion pulse.
- `cpu_rdata` out 32: read data, valid when `cpu_ready`=1 for reads.
- `acc_valid`, `acc_addr`, `acc_wdata`, `acc_wstrb`, `acc_ready`, `acc_rdata`: accelerator port, same widths and semantics as the CPU port.
- `mem_renb` out 1, `mem_raddr` out ADDR_W: dmem read port.
- `mem_wenb` out 1, `mem_wstrb` out 4, `mem_waddr` out ADDR_W, `mem_wdata` out 32: dmem write port.
- `mem_rdata` in 32: dmem registered read data.
- `arb_busy` out 1: transaction in flight.
- `arb_owner` out 1: owner of current/last transaction; 0 = CPU, 1 = accel.

## Operation
- FSM states: IDLE, WAIT.
- IDLE with any valid: pick winner, issue to memory combinationally this cycle, load latency counter with `MEM_DELAY`, go to WAIT, latch owner.
- Winner rule: CPU if `cpu_valid` and not (`acc_valid` and `STARVE_LIMIT`≠0 and `starve_cnt`≥`STARVE_LIMIT`); else accel.
- `starve_cnt` (8-bit): +1 (saturating at 255) on each issue where CPU wins while `acc_valid`=1; cleared on every accel issue; otherwise unchanged.
- Issue cycle: read (wstrb=0) drives `mem_renb`=1, `mem_raddr`=addr, `mem_wenb`=0. Write drives `mem_wenb`=1, `mem_waddr`/`mem_wstrb`/`mem_wdata` from the winner, `mem_renb`=0.
- In all non-issue cycles, all `mem_*` outputs are 0.
- WAIT: counter decrements each cycle. The owner's ready is asserted in the cycle where counter = 1 (registered). Return to IDLE on the following edge.
- `cpu_rdata` = `acc_rdata` = `mem_rdata`, passthrough. Read data are valid only with the owner's ready. Read data are don't-care for writes.
- Requests arriving during WAIT wait; requesters keep `valid`/addr/data stable until ready.
- The completed requester drops `valid` the cycle after ready (picorv32 behaviour). The arbiter does not filter re-requests.

## Timing
- Issue in cycle T → owner ready high exactly in cycle T+`MEM_DELAY`, one cycle wide. Earliest next issue is T+`MEM_DELAY`+1.
- Throughput: one access per `MEM_DELAY`+1 cycles.
- `arb_busy`=1 in cycles T+1 … T+`MEM_DELAY`.
- Both ports are never ready in the same cycle. At most one transaction is outstanding.
- Simultaneous `cpu_valid`/`acc_valid` in IDLE: resolved by the winner rule only; the loser is not issued.
- Reset values: state IDLE, counter 0, `starve_cnt` 0, `cpu_ready`=`acc_ready`=0, `arb_busy`=0, `arb_owner`=0. `mem_renb`/`mem_wenb` are forced 0 while `resetn`=0, even if a valid is high.
- Reset mid-WAIT: transaction dropped, no ready pulse. A write already issued stays committed in dmem.
- `STARVE_LIMIT`=0: `starve_cnt` still counts but never affects the grant.

## Test plan
- CPU read, `MEM_DELAY`=1, dmem[0x10]=0xDEADBEEF: `cpu_valid` at T, addr 0x10 → `mem_renb`=1, `mem_raddr`=0x10 at T; `cpu_ready`=1, `cpu_rdata`=0xDEADBEEF at T+1 only; `acc_ready` stays 0.
- Accel byte write: dmem[5]=0x11223344, `acc_wstrb`=4'b0010, `acc_wdata`=0xAABBCCDD → `mem_wenb` one cycle, `acc_ready` one cycle later. A following CPU read of 5 returns 0x1122CC44.
- `STARVE_LIMIT`=2, both valid continuously, each re-asserting after ready → grant order CPU, CPU, ACC, CPU, CPU, ACC; `starve_cnt` sequence 1, 2, 0, 1, 2, 0.
- `STARVE_LIMIT`=0, both valid continuously → CPU granted 10/10 arbitrations; `acc_ready` never asserted.
- `MEM_DELAY`=3, accel read at T → `acc_ready` only at T+3; `arb_busy` high T+1..T+3; a CPU request raised at T+1 is issued at T+4 with ready at T+7.
- `resetn` low at T+1 of a `MEM_DELAY`=3 read → no ready pulse; all outputs 0 asynchronously. After release, a new CPU read completes normally with `starve_cnt`=0.
